param_ram_be: RTL and testbench

- Next-generation parameterised single-clock simple dual-port RAM: one write port, one read port.
- Adds per-byte write enables, a configurable read pipeline depth with a data_valid strobe, and a selectable read-during-write policy.
- Adds hardware zero-initialisation after reset (init FSM) and out-of-range address detection.
- Used as the generic storage primitive under FIFOs, buffers and register files in the design.

---
 rtl/param_ram_pkg.sv | 19 +
 rtl/param_ram_rd_pipe.sv | 51 +++++
 rtl/param_ram_be.sv | 167 ++++++++++++++++
 tb/tb_param_ram_be.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_ram_pkg.sv
// Shared types and helpers for the byte-enabled parameterised RAM.
package param_ram_pkg;

   // The init FSM runs once after every reset, then the RAM stays in run.
   typedef enum logic {
      RAM_INIT = 1'b0,
      RAM_RUN  = 1'b1
   } ram_state_t;

   // Read-during-write result on a same-address collision.
   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Number of byte-enable lanes in one word.
   function automatic int num_lanes(input int data_width, input int byte_w);
      return data_width / byte_w;
   endfunction

endpackage

// File: rtl/param_ram_rd_pipe.sv
// Read-side shift pipeline: carries data, valid and the out-of-range flag
// through LATENCY register stages. Each stage's data only moves when the
// stage feeding it is valid, so the last stage holds the most recent read
// between reads.
module param_ram_rd_pipe #(
   parameter int LATENCY = 1,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_vld,
   input  logic          i_err,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   output logic          o_err,
   output logic [DW-1:0] o_dat
);

   logic [LATENCY-1:0] r_vld;
   logic [LATENCY-1:0] r_err;
   logic [DW-1:0]      r_dat [LATENCY];

   // Shift the pipeline every cycle; reset flushes all in-flight reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         r_err <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            r_dat[i] <= '0;
         end
      end else begin
         r_vld[0] <= i_vld;
         r_err[0] <= i_err;
         if (i_vld) begin
            r_dat[0] <= i_dat;
         end
         for (int i = 1; i < LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_err[i] <= r_err[i-1];
            if (r_vld[i-1]) begin
               r_dat[i] <= r_dat[i-1];
            end
         end
      end
   end

   assign o_vld = r_vld[LATENCY-1];
   assign o_err = r_err[LATENCY-1];
   assign o_dat = r_dat[LATENCY-1];

endmodule

// File: rtl/param_ram_be.sv
// Simple dual-port RAM with per-byte write enables, a 1- or 2-stage read
// pipeline, selectable read-during-write result, hardware zero-fill after
// reset and out-of-range address detection.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RAM_INIT | zeroing one word per cycle, user requests are dropped
// RAM_RUN  | normal read/write service
module param_ram_be
   import param_ram_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int BYTE_W       = 8,
   parameter int ADDR_WIDTH   = 10,
   parameter int DEPTH        = 1024,
   parameter int READ_LATENCY = 1,
   parameter int RDW_MODE     = 0
) (
   input  logic                                        clk,
   input  logic                                        rst,
   output logic                                        init_busy,
   input  logic [ADDR_WIDTH-1:0]                       write_addr,
   input  logic                                        write_enable,
   input  logic [num_lanes(DATA_WIDTH, BYTE_W)-1:0]    byte_en,
   input  logic [DATA_WIDTH-1:0]                       data_in,
   input  logic [ADDR_WIDTH-1:0]                       read_addr,
   input  logic                                        read_enable,
   output logic [DATA_WIDTH-1:0]                       data_out,
   output logic                                        data_valid,
   output logic                                        addr_err
);

   localparam int NUM_LANES = num_lanes(DATA_WIDTH, BYTE_W);
   localparam int IDX_W     = ($clog2(DEPTH) > 0) ? $clog2(DEPTH) : 1;

   // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_lane_width
      $error("param_ram_be: DATA_WIDTH must be a multiple of BYTE_W");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("param_ram_be: READ_LATENCY must be 1 or 2");
   end
   if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
      $error("param_ram_be: DEPTH must lie in 1 .. 2**ADDR_WIDTH");
   end

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   ram_state_t            r_state;
   logic [ADDR_WIDTH-1:0] r_init_cnt;
   logic                  r_busy;
   logic                  r_wr_err;

   logic                  w_run;
   logic                  w_wr_oor;
   logic                  w_rd_oor;
   logic                  w_wr_go;
   logic                  w_wr_bad;
   logic                  w_rd_go;
   logic                  w_rd_bad;
   logic                  w_same_addr;
   logic [IDX_W-1:0]      w_wr_idx;
   logic [IDX_W-1:0]      w_rd_idx;
   logic [IDX_W-1:0]      w_init_idx;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic                  w_pipe_err;

   assign w_run       = (r_state == RAM_RUN);
   assign w_wr_oor    = ({1'b0, write_addr} >= DEPTH_W);
   assign w_rd_oor    = ({1'b0, read_addr} >= DEPTH_W);
   assign w_wr_go     = w_run && write_enable && !w_wr_oor;
   assign w_wr_bad    = w_run && write_enable && w_wr_oor;
   assign w_rd_go     = w_run && read_enable;
   assign w_rd_bad    = w_rd_go && w_rd_oor;
   assign w_same_addr = (write_addr == read_addr);
   assign w_wr_idx    = write_addr[IDX_W-1:0];
   assign w_rd_idx    = read_addr[IDX_W-1:0];
   assign w_init_idx  = r_init_cnt[IDX_W-1:0];

   // Init FSM: walk every address once after reset, then hand over to run.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= RAM_INIT;
         r_init_cnt <= '0;
         r_busy     <= 1'b1;
      end else begin
         case (r_state)
            RAM_INIT: begin
               r_init_cnt <= r_init_cnt + 1'b1;
               if (r_init_cnt == LAST_ADDR) begin
                  r_state <= RAM_RUN;
                  r_busy  <= 1'b0;
               end
            end
            RAM_RUN: begin
               r_state <= RAM_RUN;
            end
            default: begin
               r_state <= RAM_INIT;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   // Memory array: zero-fill during init, lane-masked user writes in run.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == RAM_INIT) begin
            r_mem[w_init_idx] <= '0;
         end else if (w_wr_go) begin
            for (int b = 0; b < NUM_LANES; b++) begin
               if (byte_en[b]) begin
                  r_mem[w_wr_idx][b*BYTE_W +: BYTE_W] <= data_in[b*BYTE_W +: BYTE_W];
               end
            end
         end
      end
   end

   // Read word feeding the pipeline. The array still holds the pre-write
   // word on a collision; in new-data mode the written lanes are overlaid.
   always_comb begin
      w_rd_word = '0;
      if (!w_rd_oor) begin
         w_rd_word = r_mem[w_rd_idx];
         if ((RDW_MODE == RDW_NEW) && w_wr_go && w_same_addr) begin
            for (int b = 0; b < NUM_LANES; b++) begin
               if (byte_en[b]) begin
                  w_rd_word[b*BYTE_W +: BYTE_W] = data_in[b*BYTE_W +: BYTE_W];
               end
            end
         end
      end
   end

   // Bad-write flag for the following cycle. When a bad read arrives on the
   // same edge, its own flag (aligned with data_valid) is the single pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= w_wr_bad && !w_rd_bad;
      end
   end

   param_ram_rd_pipe #(
      .LATENCY (READ_LATENCY),
      .DW      (DATA_WIDTH)
   ) u_rd_pipe (
      .clk   (clk),
      .rst   (rst),
      .i_vld (w_rd_go),
      .i_err (w_rd_bad),
      .i_dat (w_rd_word),
      .o_vld (data_valid),
      .o_err (w_pipe_err),
      .o_dat (data_out)
   );

   assign init_busy = r_busy;
   assign addr_err  = r_wr_err | w_pipe_err;

endmodule

// File: tb/tb_param_ram_be.sv
// Bench for param_ram_be. Two instances share one stimulus stream:
//   u_a: DEPTH 1000, READ_LATENCY 1, old-data read-during-write
//   u_b: DEPTH 1024, READ_LATENCY 2, new-data read-during-write
// A word-array reference model predicts every output of both each cycle.
module tb_param_ram_be;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  wa;
   logic [9:0]  ra;
   logic        we;
   logic        re;
   logic [3:0]  be;
   logic [31:0] din;

   logic        a_busy, a_dv, a_err;
   logic [31:0] a_do;
   logic        b_busy, b_dv, b_err;
   logic [31:0] b_do;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   param_ram_be #(
      .DATA_WIDTH(32), .BYTE_W(8), .ADDR_WIDTH(10), .DEPTH(1000),
      .READ_LATENCY(1), .RDW_MODE(0)
   ) u_a (
      .clk(clk), .rst(rst), .init_busy(a_busy),
      .write_addr(wa), .write_enable(we), .byte_en(be), .data_in(din),
      .read_addr(ra), .read_enable(re),
      .data_out(a_do), .data_valid(a_dv), .addr_err(a_err)
   );

   param_ram_be #(
      .DATA_WIDTH(32), .BYTE_W(8), .ADDR_WIDTH(10), .DEPTH(1024),
      .READ_LATENCY(2), .RDW_MODE(1)
   ) u_b (
      .clk(clk), .rst(rst), .init_busy(b_busy),
      .write_addr(wa), .write_enable(we), .byte_en(be), .data_in(din),
      .read_addr(ra), .read_enable(re),
      .data_out(b_do), .data_valid(b_dv), .addr_err(b_err)
   );

   // ---------------- reference model ----------------
   logic [31:0] mm [2][1024];
   bit          m_busy [2];
   int          m_rem  [2];
   bit          sv [2][2];
   bit          se [2][2];
   logic [31:0] sd [2][2];
   logic [31:0] e_do  [2];
   bit          e_dv  [2];
   bit          e_err [2];

   function automatic int dep_of(input int k);
      return (k == 0) ? 1000 : 1024;
   endfunction
   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 2;
   endfunction
   function automatic int rdw_of(input int k);
      return (k == 0) ? 0 : 1;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [3:0]  mask_be);
      logic [31:0] mask;
      mask = {{8{mask_be[3]}}, {8{mask_be[2]}}, {8{mask_be[1]}}, {8{mask_be[0]}}};
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   // Advance the model by one rising edge using the currently driven inputs.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         bit          rd_bad;
         bit          wr_bad;
         bit          wr_ok;
         logic [31:0] w;
         int          slot;
         rd_bad = 0;
         wr_bad = 0;
         wr_ok  = 0;
         if (rst) begin
            m_busy[k] = 1;
            m_rem[k]  = dep_of(k);
            for (int s = 0; s < 2; s++) begin
               sv[k][s] = 0;
               se[k][s] = 0;
               sd[k][s] = '0;
            end
            e_do[k]  = '0;
            e_dv[k]  = 0;
            e_err[k] = 0;
            for (int a = 0; a < 1024; a++) mm[k][a] = '0;
         end else begin
            sv[k][0] = sv[k][1];
            se[k][0] = se[k][1];
            sd[k][0] = sd[k][1];
            sv[k][1] = 0;
            se[k][1] = 0;
            if (m_busy[k]) begin
               m_rem[k]--;
               if (m_rem[k] == 0) m_busy[k] = 0;
            end else begin
               rd_bad = re && (int'(ra) >= dep_of(k));
               wr_ok  = we && (int'(wa) < dep_of(k));
               wr_bad = we && !wr_ok && !rd_bad;
               if (re) begin
                  w = rd_bad ? 32'h0 : mm[k][ra];
                  if (rdw_of(k) == 1 && wr_ok && !rd_bad && wa == ra) w = merge(w, din, be);
                  slot = lat_of(k) - 1;
                  sv[k][slot] = 1;
                  se[k][slot] = rd_bad;
                  sd[k][slot] = w;
               end
               if (wr_ok) mm[k][wa] = merge(mm[k][wa], din, be);
            end
            e_dv[k]  = sv[k][0];
            e_err[k] = se[k][0] | wr_bad;
            if (sv[k][0]) e_do[k] = sd[k][0];
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("a_init_busy",  {31'b0, a_busy}, {31'b0, m_busy[0]});
      chk("a_data_valid", {31'b0, a_dv},   {31'b0, e_dv[0]});
      chk("a_addr_err",   {31'b0, a_err},  {31'b0, e_err[0]});
      chk("a_data_out",   a_do,            e_do[0]);
      chk("b_init_busy",  {31'b0, b_busy}, {31'b0, m_busy[1]});
      chk("b_data_valid", {31'b0, b_dv},   {31'b0, e_dv[1]});
      chk("b_addr_err",   {31'b0, b_err},  {31'b0, e_err[1]});
      chk("b_data_out",   b_do,            e_do[1]);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      we = 0; re = 0; wa = '0; ra = '0; be = '0; din = '0;
   endtask

   task automatic wr(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] mask);
      we = 1; wa = addr; din = data; be = mask;
      step();
      we = 0;
   endtask

   task automatic rd(input logic [9:0] addr);
      re = 1; ra = addr;
      step();
      re = 0;
   endtask

   // Count edges until u_b leaves init; a write and read are thrown at the
   // RAM early in init and must be dropped.
   task automatic busy_count(output int n, input bit poke);
      n = 0;
      do begin
         if (poke && n == 2) begin
            we = 1; wa = 10'd5; din = 32'hFFFF_FFFF; be = 4'hF;
            re = 1; ra = 10'd5;
         end else begin
            we = 0; re = 0;
         end
         step();
         n++;
      end while (b_busy === 1'b1 && n < 1100);
   endtask

   function automatic logic [9:0] pick_addr();
      if ($urandom_range(0, 9) < 7) return 10'($urandom_range(0, 15));
      return 10'($urandom_range(990, 1023));
   endfunction

   int cnt;

   initial begin
      rst = 1;
      idle_inputs();
      step();
      step();
      chk("rst_b_busy", {31'b0, b_busy}, 32'd1);
      chk("rst_a_dout", a_do, 32'h0);

      // Zero-fill after reset; early write/read are ignored.
      rst = 0;
      busy_count(cnt, 1'b1);
      chk("busy_len_1", cnt, 32'd1024);

      rd(10'd5);
      chk("rd5_a_dv", {31'b0, a_dv}, 32'd1);
      chk("rd5_a_do", a_do, 32'h0);
      step();
      chk("rd5_b_dv", {31'b0, b_dv}, 32'd1);
      chk("rd5_b_do", b_do, 32'h0);
      rd(10'd1023);
      chk("rd1023_a_err", {31'b0, a_err}, 32'd1);
      step();
      chk("rd1023_b_do", b_do, 32'h0);
      step();

      // Byte-lane merge.
      wr(10'd10, 32'hDEAD_BEEF, 4'hF);
      wr(10'd10, 32'h0000_5500, 4'b0010);
      rd(10'd10);
      chk("merge_a_do", a_do, 32'hDEAD_55EF);
      chk("merge_a_dv", {31'b0, a_dv}, 32'd1);
      step();
      chk("merge_a_dv_strobe", {31'b0, a_dv}, 32'd0);
      chk("merge_b_dv", {31'b0, b_dv}, 32'd1);
      chk("merge_b_do", b_do, 32'hDEAD_55EF);
      step();

      // Back-to-back reads.
      re = 1; ra = 10'd10;
      step();
      ra = 10'd11;
      step();
      re = 0;
      chk("b2b_a_do", a_do, 32'h0);
      chk("b2b_b_dv0", {31'b0, b_dv}, 32'd1);
      chk("b2b_b_do0", b_do, 32'hDEAD_55EF);
      step();
      chk("b2b_b_dv1", {31'b0, b_dv}, 32'd1);
      chk("b2b_b_do1", b_do, 32'h0);
      step();
      chk("b2b_b_dv2", {31'b0, b_dv}, 32'd0);

      // Same-address read-during-write.
      we = 1; wa = 10'd10; din = 32'h1111_1111; be = 4'hF; re = 1; ra = 10'd10;
      step();
      idle_inputs();
      chk("rdw_old_a", a_do, 32'hDEAD_55EF);
      step();
      chk("rdw_new_b", b_do, 32'h1111_1111);
      wr(10'd10, 32'hDEAD_55EF, 4'hF);
      we = 1; wa = 10'd10; din = 32'h1111_1111; be = 4'b0001; re = 1; ra = 10'd10;
      step();
      idle_inputs();
      chk("rdw_lane_a", a_do, 32'hDEAD_55EF);
      step();
      chk("rdw_lane_b", b_do, 32'hDEAD_5511);

      // Out-of-range on the 1000-word instance.
      wr(10'd1010, 32'h1234_5678, 4'hF);
      chk("oor_wr_err", {31'b0, a_err}, 32'd1);
      step();
      chk("oor_wr_err_end", {31'b0, a_err}, 32'd0);
      rd(10'd1010);
      chk("oor_rd_dv", {31'b0, a_dv}, 32'd1);
      chk("oor_rd_err", {31'b0, a_err}, 32'd1);
      chk("oor_rd_do", a_do, 32'h0);
      step();
      step();

      // Randomised traffic.
      for (int i = 0; i < 1500; i++) begin
         we  = 1'($urandom_range(0, 1));
         re  = 1'($urandom_range(0, 1));
         wa  = pick_addr();
         ra  = ($urandom_range(0, 3) == 0) ? wa : pick_addr();
         be  = 4'($urandom_range(0, 15));
         din = $urandom;
         step();
      end
      idle_inputs();
      step();
      step();

      // Reset in the middle of init.
      rst = 1;
      step();
      rst = 0;
      repeat (500) step();
      rst = 1;
      step();
      rst = 0;
      busy_count(cnt, 1'b0);
      chk("busy_len_2", cnt, 32'd1024);

      // Reset with two reads in flight.
      wr(10'd10, 32'hAAAA_5555, 4'hF);
      re = 1; ra = 10'd10;
      step();
      ra = 10'd11;
      step();
      re = 0;
      rst = 1;
      step();
      chk("flush_b_dv", {31'b0, b_dv}, 32'd0);
      chk("flush_a_dv", {31'b0, a_dv}, 32'd0);
      rst = 0;
      busy_count(cnt, 1'b0);
      chk("busy_len_3", cnt, 32'd1024);
      rd(10'd10);
      chk("rezero_a_dv", {31'b0, a_dv}, 32'd1);
      chk("rezero_a_do", a_do, 32'h0);
      step();
      chk("rezero_b_dv", {31'b0, b_dv}, 32'd1);
      chk("rezero_b_do", b_do, 32'h0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
